// File: rtl/mul_core_pipe.sv
// mul_core_pipe -- three-stage pipelined posit multiplier core.
//
// Works on decoded operand fields and hands unrounded product fields plus
// round/sticky bits to the downstream rounder/encoder.
//   S1: specials, fraction alignment, scale sum
//   S2: fraction multiply
//   S3: normalise, regime clamp, special override
// One global enable (en = !out_valid | out_ready) advances all stages at
// once, so bubbles are kept and order is preserved.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid / in_ready      operand handshake
//   p{1,2}_is_zero/_is_nar   operand special flags
//   p{1,2}_sign/_reg_len/_k/_exp/_mant  decoded operand fields
//   out_valid / out_ready    result handshake
//   pout_*                   product fields, round/sticky and saturation flag
module mul_core_pipe #(
    parameter int N  = 8,
    parameter int ES = 0,
    parameter int S  = $clog2(N),
    parameter int EW = (ES > 0) ? ES : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          p1_is_zero,
    input  logic          p1_is_nar,
    input  logic          p1_sign,
    input  logic [S-1:0]  p1_reg_len,
    input  logic [N-1:0]  p1_k,
    input  logic [EW-1:0] p1_exp,
    input  logic [N-1:0]  p1_mant,
    input  logic          p2_is_zero,
    input  logic          p2_is_nar,
    input  logic          p2_sign,
    input  logic [S-1:0]  p2_reg_len,
    input  logic [N-1:0]  p2_k,
    input  logic [EW-1:0] p2_exp,
    input  logic [N-1:0]  p2_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          pout_is_zero,
    output logic          pout_is_nar,
    output logic          pout_sign,
    output logic [N-1:0]  pout_k,
    output logic [EW-1:0] pout_exp,
    output logic [N-1:0]  pout_frac,
    output logic          pout_round,
    output logic          pout_sticky,
    output logic          pout_sat
);

    localparam int SW = N + ES + 2;
    localparam int PW = 2 * N;
    localparam logic signed [SW:0] KMAX_S = (SW+1)'(N - 2);
    localparam logic signed [SW:0] KMIN_S = -KMAX_S;

    // Place the F valid fraction bits directly under an explicit hidden 1.
    function automatic logic [N-1:0] align_frac(input logic [S-1:0] reg_len,
                                                input logic [N-1:0] mant);
        int            f;
        int            sh;
        logic [N-2:0]  m;
        f = N - 1 - int'(reg_len) - ES;
        if (f < 0) f = 0;
        sh = N - 1 - f;
        m  = (N-1)'(mant << sh);
        return {1'b1, m};
    endfunction

    function automatic logic signed [SW-1:0] calc_scale(input logic [N-1:0]  ka,
                                                        input logic [N-1:0]  kb,
                                                        input logic [EW-1:0] ea,
                                                        input logic [EW-1:0] eb);
        logic signed [SW-1:0] ksum;
        logic signed [SW-1:0] esum;
        ksum = $signed({{(SW-N){ka[N-1]}}, ka}) + $signed({{(SW-N){kb[N-1]}}, kb});
        esum = $signed({{(SW-EW){1'b0}}, ea}) + $signed({{(SW-EW){1'b0}}, eb});
        if (ES == 0) esum = '0;
        return (ksum <<< ES) + esum;
    endfunction

    logic en;
    logic v1_q, v2_q, v3_q;

    // Stage 1
    logic                 s1_nar_d, s1_zero_d, s1_sign_d;
    logic [N-1:0]         s1_f1_d, s1_f2_d;
    logic signed [SW-1:0] s1_scale_d;
    logic                 s1_nar_q, s1_zero_q, s1_sign_q;
    logic [N-1:0]         s1_f1_q, s1_f2_q;
    logic signed [SW-1:0] s1_scale_q;

    // Stage 2
    logic [PW-1:0]        s2_prod_d;
    logic                 s2_nar_q, s2_zero_q, s2_sign_q;
    logic [PW-1:0]        s2_prod_q;
    logic signed [SW-1:0] s2_scale_q;

    // Stage 3 / output
    logic [PW-2:0]        frac_full;
    logic signed [SW:0]   scale_n;
    logic signed [SW:0]   k_full;
    logic                 o_zero_d, o_nar_d, o_sign_d, o_round_d, o_sticky_d, o_sat_d;
    logic [N-1:0]         o_k_d, o_frac_d;
    logic [EW-1:0]        o_exp_d;
    logic                 o_zero_q, o_nar_q, o_sign_q, o_round_q, o_sticky_q, o_sat_q;
    logic [N-1:0]         o_k_q, o_frac_q;
    logic [EW-1:0]        o_exp_q;

    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;

    always_comb begin
        s1_nar_d   = p1_is_nar | p2_is_nar;
        s1_zero_d  = !s1_nar_d && (p1_is_zero || p2_is_zero);
        s1_sign_d  = p1_sign ^ p2_sign;
        s1_f1_d    = align_frac(p1_reg_len, p1_mant);
        s1_f2_d    = align_frac(p2_reg_len, p2_mant);
        s1_scale_d = calc_scale(p1_k, p2_k, p1_exp, p2_exp);
    end

    always_comb begin
        s2_prod_d = PW'(s1_f1_q) * PW'(s1_f2_q);
    end

    always_comb begin
        // Product of two [1,2) fractions is in [1,4): top bit set means one
        // extra power of two, otherwise shift left by one to drop the hidden bit.
        frac_full  = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
        scale_n    = $signed({s2_scale_q[SW-1], s2_scale_q}) + $signed({{SW{1'b0}}, s2_prod_q[PW-1]});
        k_full     = scale_n >>> ES;
        o_zero_d   = s2_zero_q;
        o_nar_d    = s2_nar_q;
        o_sign_d   = s2_sign_q;
        o_k_d      = k_full[N-1:0];
        o_exp_d    = (ES > 0) ? scale_n[EW-1:0] : '0;
        o_frac_d   = frac_full[PW-2 -: N];
        o_round_d  = frac_full[N-2];
        o_sticky_d = |frac_full[N-3:0];
        o_sat_d    = 1'b0;
        if (k_full > KMAX_S || k_full < KMIN_S) begin
            o_k_d      = (k_full > KMAX_S) ? KMAX_S[N-1:0] : KMIN_S[N-1:0];
            o_exp_d    = '0;
            o_frac_d   = '0;
            o_round_d  = 1'b0;
            o_sticky_d = 1'b0;
            o_sat_d    = 1'b1;
        end
        if (s2_nar_q || s2_zero_q) begin
            o_sign_d   = 1'b0;
            o_k_d      = '0;
            o_exp_d    = '0;
            o_frac_d   = '0;
            o_round_d  = 1'b0;
            o_sticky_d = 1'b0;
            o_sat_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_nar_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_f1_q    <= '0;
            s1_f2_q    <= '0;
            s1_scale_q <= '0;
        end else if (en && in_valid) begin
            s1_nar_q   <= s1_nar_d;
            s1_zero_q  <= s1_zero_d;
            s1_sign_q  <= s1_sign_d;
            s1_f1_q    <= s1_f1_d;
            s1_f2_q    <= s1_f2_d;
            s1_scale_q <= s1_scale_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_nar_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_prod_q  <= '0;
            s2_scale_q <= '0;
        end else if (en && v1_q) begin
            s2_nar_q   <= s1_nar_q;
            s2_zero_q  <= s1_zero_q;
            s2_sign_q  <= s1_sign_q;
            s2_prod_q  <= s2_prod_d;
            s2_scale_q <= s1_scale_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_zero_q   <= 1'b0;
            o_nar_q    <= 1'b0;
            o_sign_q   <= 1'b0;
            o_k_q      <= '0;
            o_exp_q    <= '0;
            o_frac_q   <= '0;
            o_round_q  <= 1'b0;
            o_sticky_q <= 1'b0;
            o_sat_q    <= 1'b0;
        end else if (en && v2_q) begin
            o_zero_q   <= o_zero_d;
            o_nar_q    <= o_nar_d;
            o_sign_q   <= o_sign_d;
            o_k_q      <= o_k_d;
            o_exp_q    <= o_exp_d;
            o_frac_q   <= o_frac_d;
            o_round_q  <= o_round_d;
            o_sticky_q <= o_sticky_d;
            o_sat_q    <= o_sat_d;
        end
    end

    assign pout_is_zero = o_zero_q;
    assign pout_is_nar  = o_nar_q;
    assign pout_sign    = o_sign_q;
    assign pout_k       = o_k_q;
    assign pout_exp     = o_exp_q;
    assign pout_frac    = o_frac_q;
    assign pout_round   = o_round_q;
    assign pout_sticky  = o_sticky_q;
    assign pout_sat     = o_sat_q;

endmodule

// File: tb/tb_mul_core_pipe.sv
// Directed testbench for mul_core_pipe: an N=8/ES=0 instance for streaming,
// backpressure, specials and reset, and an N=16/ES=1 instance for exponent
// handling and regime clamping.
module tb_mul_core_pipe;

    // operand: {is_zero, is_nar, sign, reg_len, k, mant}
    typedef struct packed {
        logic       z;
        logic       n;
        logic       s;
        logic [2:0] rl;
        logic [7:0] k;
        logic [7:0] m;
    } op8_t;

    // expected result: {is_zero, is_nar, sign, k, frac, round, sticky, sat}
    typedef struct packed {
        logic       z;
        logic       n;
        logic       s;
        logic [7:0] k;
        logic [7:0] f;
        logic       r;
        logic       st;
        logic       sat;
    } res8_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=8, ES=0 instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic       a_z, a_n, a_s, b_z, b_n, b_s;
    logic [2:0] a_rl, b_rl;
    logic [7:0] a_k, a_m, b_k, b_m;
    logic       a_e, b_e;
    logic       o8_zero, o8_nar, o8_sign, o8_exp, o8_round, o8_sticky, o8_sat;
    logic [7:0] o8_k, o8_frac;
    logic [22:0] out_bus8;

    // N=16, ES=1 instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic        c_z, c_n, c_s, d_z, d_n, d_s;
    logic [3:0]  c_rl, d_rl;
    logic [15:0] c_k, c_m, d_k, d_m;
    logic        c_e, d_e;
    logic        o16_zero, o16_nar, o16_sign, o16_exp, o16_round, o16_sticky, o16_sat;
    logic [15:0] o16_k, o16_frac;

    op8_t  va [13];
    op8_t  vb [13];
    res8_t vr [13];

    int n_checks = 0;
    int n_fail   = 0;

    assign out_bus8 = {o8_zero, o8_nar, o8_sign, o8_k, o8_exp, o8_frac, o8_round, o8_sticky, o8_sat};

    mul_core_pipe #(.N(8), .ES(0)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .p1_is_zero(a_z), .p1_is_nar(a_n), .p1_sign(a_s), .p1_reg_len(a_rl),
        .p1_k(a_k), .p1_exp(a_e), .p1_mant(a_m),
        .p2_is_zero(b_z), .p2_is_nar(b_n), .p2_sign(b_s), .p2_reg_len(b_rl),
        .p2_k(b_k), .p2_exp(b_e), .p2_mant(b_m),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .pout_is_zero(o8_zero), .pout_is_nar(o8_nar), .pout_sign(o8_sign),
        .pout_k(o8_k), .pout_exp(o8_exp), .pout_frac(o8_frac),
        .pout_round(o8_round), .pout_sticky(o8_sticky), .pout_sat(o8_sat)
    );

    mul_core_pipe #(.N(16), .ES(1)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .p1_is_zero(c_z), .p1_is_nar(c_n), .p1_sign(c_s), .p1_reg_len(c_rl),
        .p1_k(c_k), .p1_exp(c_e), .p1_mant(c_m),
        .p2_is_zero(d_z), .p2_is_nar(d_n), .p2_sign(d_s), .p2_reg_len(d_rl),
        .p2_k(d_k), .p2_exp(d_e), .p2_mant(d_m),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .pout_is_zero(o16_zero), .pout_is_nar(o16_nar), .pout_sign(o16_sign),
        .pout_k(o16_k), .pout_exp(o16_exp), .pout_frac(o16_frac),
        .pout_round(o16_round), .pout_sticky(o16_sticky), .pout_sat(o16_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_res8(input int i);
        chk($sformatf("v%0d_zero", i),   32'(o8_zero),   32'(vr[i].z));
        chk($sformatf("v%0d_nar", i),    32'(o8_nar),    32'(vr[i].n));
        chk($sformatf("v%0d_sign", i),   32'(o8_sign),   32'(vr[i].s));
        chk($sformatf("v%0d_k", i),      32'(o8_k),      32'(vr[i].k));
        chk($sformatf("v%0d_exp", i),    32'(o8_exp),    32'd0);
        chk($sformatf("v%0d_frac", i),   32'(o8_frac),   32'(vr[i].f));
        chk($sformatf("v%0d_round", i),  32'(o8_round),  32'(vr[i].r));
        chk($sformatf("v%0d_sticky", i), 32'(o8_sticky), 32'(vr[i].st));
        chk($sformatf("v%0d_sat", i),    32'(o8_sat),    32'(vr[i].sat));
    endtask

    // Streams vectors [first, first+cnt) through the N=8 core; out_ready is
    // held low for stall_len cycles starting at cycle stall_at.
    task automatic run8(input int first, input int cnt, input int stall_at, input int stall_len);
        int          idx, done, cyc, pi, pc;
        int          q_i[$];
        int          q_c[$];
        logic [22:0] snap;
        bit          prev_stall;
        idx = first; done = 0; cyc = 0; prev_stall = 0; snap = '0;
        while (done < cnt && cyc < 100) begin
            @(negedge clk);
            out_ready8 = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid8  = (idx < first + cnt);
            if (in_valid8) begin
                {a_z, a_n, a_s, a_rl, a_k, a_m} = va[idx];
                {b_z, b_n, b_s, b_rl, b_k, b_m} = vb[idx];
            end
            #1;
            if (out_valid8 && !out_ready8) begin
                chk("stall_in_ready", 32'(in_ready8), 32'd0);
                if (prev_stall) chk("stall_hold", 32'(out_bus8), 32'(snap));
                snap = out_bus8;
                prev_stall = 1;
            end else begin
                prev_stall = 0;
            end
            if (out_valid8 && out_ready8) begin
                chk("out_expected", 32'(q_i.size() != 0), 32'd1);
                if (q_i.size() != 0) begin
                    pi = q_i.pop_front();
                    pc = q_c.pop_front();
                    check_res8(pi);
                    if (stall_len == 0) chk($sformatf("v%0d_latency", pi), 32'(cyc - pc), 32'd3);
                    done++;
                end
            end
            if (in_valid8 && in_ready8) begin
                q_i.push_back(idx);
                q_c.push_back(cyc);
                idx++;
            end
            cyc++;
        end
        chk("run8_complete", 32'(done), 32'(cnt));
        @(negedge clk);
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
    endtask

    task automatic run16(input string tag,
                         input logic [3:0] rl1, input logic [15:0] k1, input logic e1, input logic [15:0] m1,
                         input logic [3:0] rl2, input logic [15:0] k2, input logic e2, input logic [15:0] m2,
                         input logic [15:0] ek, input logic ee, input logic [15:0] ef, input logic esat);
        int w;
        @(negedge clk);
        {c_z, c_n, c_s, c_rl, c_k, c_e, c_m} = {1'b0, 1'b0, 1'b0, rl1, k1, e1, m1};
        {d_z, d_n, d_s, d_rl, d_k, d_e, d_m} = {1'b0, 1'b0, 1'b0, rl2, k2, e2, m2};
        in_valid16 = 1'b1;
        #1 chk({tag, "_in_ready"}, 32'(in_ready16), 32'd1);
        @(negedge clk);
        in_valid16 = 1'b0;
        w = 0;
        while (!out_valid16 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"},   32'(out_valid16), 32'd1);
        chk({tag, "_latency"}, 32'(w),           32'd2);
        chk({tag, "_k"},       32'(o16_k),       32'(ek));
        chk({tag, "_exp"},     32'(o16_exp),     32'(ee));
        chk({tag, "_frac"},    32'(o16_frac),    32'(ef));
        chk({tag, "_sat"},     32'(o16_sat),     32'(esat));
        chk({tag, "_rs"},      32'({o16_round, o16_sticky, o16_zero, o16_nar, o16_sign}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //            z     n     s     rl    k      m
        va[0]  = {1'b0, 1'b0, 1'b0, 3'd3, 8'h01, 8'h00};  // 2.0
        vb[0]  = {1'b0, 1'b0, 1'b0, 3'd4, 8'h02, 8'h01};  // 4.5
        va[1]  = {1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h10};  // 1.5
        vb[1]  = {1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h10};  // 1.5
        va[2]  = {1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h1F};  // f=0xFC
        vb[2]  = {1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h1F};
        va[3]  = {1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h13};  // f=0xCC
        vb[3]  = {1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h17};  // f=0xDC
        va[4]  = {1'b0, 1'b0, 1'b0, 3'd3, 8'hFE, 8'h00};  // 0.25
        vb[4]  = {1'b0, 1'b0, 1'b0, 3'd2, 8'hFF, 8'h00};  // 0.5
        va[5]  = {1'b0, 1'b0, 1'b0, 3'd6, 8'h04, 8'h01};
        vb[5]  = {1'b0, 1'b0, 1'b0, 3'd5, 8'h03, 8'h01};
        va[6]  = {1'b0, 1'b0, 1'b1, 3'd5, 8'hFC, 8'h00};
        vb[6]  = {1'b0, 1'b0, 1'b0, 3'd4, 8'hFD, 8'h00};
        va[7]  = {1'b0, 1'b0, 1'b0, 3'd5, 8'h03, 8'h00};
        vb[7]  = {1'b0, 1'b0, 1'b0, 3'd5, 8'h03, 8'h00};
        va[8]  = {1'b0, 1'b0, 1'b0, 3'd5, 8'h03, 8'h02};  // 1.5 * 2^3
        vb[8]  = {1'b0, 1'b0, 1'b0, 3'd5, 8'h03, 8'h02};
        va[9]  = {1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};  // NaR
        vb[9]  = {1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00};  // zero
        va[10] = {1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00};  // zero
        vb[10] = {1'b0, 1'b0, 1'b1, 3'd3, 8'h01, 8'h08};  // -3.0
        va[11] = {1'b0, 1'b0, 1'b1, 3'd6, 8'h04, 8'h01};
        vb[11] = {1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};  // NaR
        va[12] = {1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00};
        vb[12] = {1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00};
        //            z     n     s     k      frac   r     st    sat
        vr[0]  = {1'b0, 1'b0, 1'b0, 8'h03, 8'h20, 1'b0, 1'b0, 1'b0};
        vr[1]  = {1'b0, 1'b0, 1'b0, 8'h01, 8'h20, 1'b0, 1'b0, 1'b0};
        vr[2]  = {1'b0, 1'b0, 1'b1, 8'h01, 8'hF0, 1'b0, 1'b1, 1'b0};
        vr[3]  = {1'b0, 1'b0, 1'b1, 8'h01, 8'h5E, 1'b1, 1'b1, 1'b0};
        vr[4]  = {1'b0, 1'b0, 1'b0, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b0};
        vr[5]  = {1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 1'b1};
        vr[6]  = {1'b0, 1'b0, 1'b1, 8'hFA, 8'h00, 1'b0, 1'b0, 1'b1};
        vr[7]  = {1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 1'b0};
        vr[8]  = {1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 1'b1};
        vr[9]  = {1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vr[10] = {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vr[11] = {1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vr[12] = {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        {a_z, a_n, a_s, a_rl, a_k, a_m} = '0; a_e = 1'b0;
        {b_z, b_n, b_s, b_rl, b_k, b_m} = '0; b_e = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        {c_z, c_n, c_s, c_rl, c_k, c_e, c_m} = '0;
        {d_z, d_n, d_s, d_rl, d_k, d_e, d_m} = '0;

        #3;
        chk("rst_out_valid8",  32'(out_valid8),  32'd0);
        chk("rst_in_ready8",   32'(in_ready8),   32'd1);
        chk("rst_bus8",        32'(out_bus8),    32'd0);
        chk("rst_out_valid16", 32'(out_valid16), 32'd0);
        chk("rst_in_ready16",  32'(in_ready16),  32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run8(0, 1, 0, 0);   // 2.0 x 4.5
        run8(1, 1, 0, 0);   // 1.5 x 1.5, mantissa carry
        run8(2, 6, 3, 5);   // six back-to-back with a 5-cycle output stall
        run8(8, 5, 0, 0);   // carry into clamp, specials

        //     tag    rl1    k1        e1    m1        rl2    k2        e2    m2        k         exp   frac      sat
        run16("e11",  4'd2, 16'h0000, 1'b1, 16'h0000, 4'd2, 16'h0000, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b0);
        run16("k7e1", 4'd9, 16'h0007, 1'b1, 16'h0000, 4'd9, 16'h0007, 1'b1, 16'h0000, 16'h000E, 1'b0, 16'h0000, 1'b1);
        run16("k7e0", 4'd9, 16'h0007, 1'b0, 16'h0000, 4'd9, 16'h0007, 1'b0, 16'h0000, 16'h000E, 1'b0, 16'h0000, 1'b0);
        run16("odd",  4'd3, 16'h0001, 1'b1, 16'h0000, 4'd2, 16'h0000, 1'b0, 16'h0000, 16'h0001, 1'b1, 16'h0000, 1'b0);
        run16("kneg", 4'd9, 16'hFFF8, 1'b0, 16'h0000, 4'd9, 16'hFFF8, 1'b0, 16'h0000, 16'hFFF2, 1'b0, 16'h0000, 1'b1);
        run16("m1",   4'd2, 16'hFFFF, 1'b0, 16'h0000, 4'd2, 16'h0000, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
        run16("f15",  4'd2, 16'h0000, 1'b0, 16'h0800, 4'd2, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b1, 16'h2000, 1'b0);

        // Reset with one result at the output and two operations behind it.
        @(negedge clk);
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        {a_z, a_n, a_s, a_rl, a_k, a_m} = va[0];
        {b_z, b_n, b_s, b_rl, b_k, b_m} = vb[0];
        @(negedge clk);
        {a_z, a_n, a_s, a_rl, a_k, a_m} = va[3];
        {b_z, b_n, b_s, b_rl, b_k, b_m} = vb[3];
        @(negedge clk);
        {a_z, a_n, a_s, a_rl, a_k, a_m} = va[4];
        {b_z, b_n, b_s, b_rl, b_k, b_m} = vb[4];
        @(negedge clk);
        in_valid8 = 1'b0;
        #1 chk("t6_pre_valid", 32'(out_valid8), 32'd1);
        chk("t6_pre_k", 32'(o8_k), 32'h03);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_valid",    32'(out_valid8), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready8),  32'd1);
        chk("t6_rst_bus",      32'(out_bus8),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t6_post_valid%0d", i), 32'(out_valid8), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
